// File: rtl/register_file16.sv
// register_file16: sixteen 32-bit registers, one-hot write/read selects.
// Optional R0 base-address zeroing under macro R0_BAOUT_EN.
module register_file16 (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] r_in,
  input  logic [15:0] r_out,
  input  logic        ba_out,
  input  logic [31:0] bus_in,
  output logic [31:0] bus_out,
  output logic        rd_valid,
  output logic        sel_err
);

  logic [31:0] regs [16];
  logic [31:0] rdData;
  logic        wrOne;
  logic        wrMulti;
  logic        rdOne;
  logic        rdMulti;
  logic        baZero;

  assign wrOne   = $onehot(r_in);
  assign wrMulti = (r_in != 16'h0000) && !wrOne;
  assign rdOne   = $onehot(r_out);
  assign rdMulti = (r_out != 16'h0000) && !rdOne;

`ifdef R0_BAOUT_EN
  assign baZero = ba_out && (r_out == 16'h0001);
`else
  assign baZero = ba_out & 1'b0;
`endif

  // Register array: clear on clr, else load on a single legal write select.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wrOne) begin
      for (int i = 0; i < 16; i++)
        if (r_in[i]) regs[i] <= bus_in;
    end
  end

  // Sticky error on any multi-hot select; only clr clears it.
  always_ff @(posedge clk) begin
    if (clr) sel_err <= 1'b0;
    else if (wrMulti || rdMulti) sel_err <= 1'b1;
  end

  // Combinational read mux; illegal or empty selects read as zero.
  always_comb begin
    rdData = '0;
    for (int i = 0; i < 16; i++)
      if (r_out[i]) rdData = rdData | regs[i];
    rd_valid = rdOne;
    bus_out  = (rdOne && !baZero) ? rdData : 32'h0;
  end

endmodule

// File: doc/register_file16.md
REGISTER_FILE16 -- requirements
Module: register_file16

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: clr  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: r_in  input  16  one-hot write enables from the 4-to-16 decoder (gated with Rin); bit i selects R(i).
REQ-004 SHALL have port: r_out  input  16  one-hot read selects from the 4-to-16 decoder (gated with Rout); bit i selects R(i).
REQ-005 SHALL have port: ba_out  input  1  base-address read qualifier for R0.
REQ-006 SHALL have port: bus_in  input  32  write data from the shared bus.
REQ-007 SHALL have port: bus_out  output  32  read data to the bus multiplexer.
REQ-008 SHALL have port: rd_valid  output  1  high when exactly one r_out bit is set.
REQ-009 SHALL have port: sel_err  output  1  sticky flag for an illegal (multi-hot) r_in or r_out.

Function
REQ-010 SHALL hold sixteen 32-bit registers R0..R15.
REQ-011 SHALL, on a rising edge with clr low and exactly one r_in bit i set, load bus_in into R(i); R(i) holds the new value from the next cycle.
REQ-012 SHALL leave every register unchanged when r_in is all zero.
REQ-013 SHALL leave every register unchanged when r_in has two or more bits set, and SHALL set sel_err on that edge.
REQ-014 SHALL drive bus_out combinationally with R(i) when exactly one r_out bit i is set, with zero added latency.
REQ-015 SHALL drive bus_out to 0 and rd_valid low when r_out is all zero.
REQ-016 SHALL drive bus_out to 0 and rd_valid low when r_out has two or more bits set, and SHALL set sel_err on the next rising edge.
REQ-017 SHALL return the pre-edge (old) contents on bus_out when the same register is read and written in one cycle; the new value appears in the following cycle.
REQ-018 SHALL set sel_err only on a rising edge and keep it set until clr, regardless of later legal traffic.
REQ-019 SHALL give clr priority over any simultaneous write or error-flag update.

Reset
REQ-020 SHALL, on a rising edge with clr high, clear R0..R15 to 0x00000000 and sel_err to 0.
REQ-021 SHALL discard any write presented in the clr cycle; a write in progress when clr asserts is lost.
REQ-022 SHALL keep bus_out and rd_valid purely combinational from r_out and register contents, so after reset any single-select read returns 0.

Configuration
REQ-023 SHALL compile the R0 base-address zeroing only when macro R0_BAOUT_EN is defined.
REQ-024 SHALL, with R0_BAOUT_EN defined, drive bus_out to 0 when ba_out is high and r_out equals 16'h0001; rd_valid stays high.
REQ-025 SHALL, with R0_BAOUT_EN undefined, ignore ba_out and treat R0 like every other register.

Verification
REQ-026 SHALL cover: clr high one edge after random writes -> all sixteen reads return 0x00000000, sel_err=0.
REQ-027 SHALL cover: r_in=16'h0020, bus_in=0xDEADBEEF, one edge; then r_out=16'h0020 -> bus_out=0xDEADBEEF, rd_valid=1.
REQ-028 SHALL cover: R3=0x11111111; r_in=r_out=16'h0008, bus_in=0x22222222 -> bus_out=0x11111111 before the edge, 0x22222222 after it.
REQ-029 SHALL cover: r_in=16'h0006, bus_in=0xFFFFFFFF -> R1 and R2 unchanged, sel_err=1 after the edge and still 1 after 10 legal cycles.
REQ-030 SHALL cover: r_out=16'h8001 -> bus_out=0, rd_valid=0, sel_err=1 after the next edge.
REQ-031 SHALL cover: R0=0x00000040, r_out=16'h0001, ba_out=1 -> bus_out=0 with R0_BAOUT_EN defined, 0x00000040 without it.
